// File: rtl/line_dispatcher_if.sv
// Handshake bundles around the line dispatcher: the command stream from the
// vector generator and the issue/done handshake towards the rasterizer.

interface line_cmd_if #(
    parameter int COORD_W = 11,
    parameter int COLOR_W = 4
);
    logic               cmdValid;
    logic               cmdReady;
    logic [COORD_W-1:0] cmdStartX;
    logic [COORD_W-1:0] cmdStartY;
    logic [COORD_W-1:0] cmdEndX;
    logic [COORD_W-1:0] cmdEndY;
    logic [COLOR_W-1:0] cmdColor;

    modport master (
        output cmdValid, cmdStartX, cmdStartY, cmdEndX, cmdEndY, cmdColor,
        input  cmdReady
    );

    modport slave (
        input  cmdValid, cmdStartX, cmdStartY, cmdEndX, cmdEndY, cmdColor,
        output cmdReady
    );
endinterface

interface line_rast_if #(
    parameter int COORD_W = 11,
    parameter int COLOR_W = 4
);
    logic               readyIn;
    logic               rastReady;
    logic               rastDone;
    logic [COORD_W-1:0] startX;
    logic [COORD_W-1:0] startY;
    logic [COORD_W-1:0] endX;
    logic [COORD_W-1:0] endY;
    logic [COLOR_W-1:0] lineColor;

    modport master (
        output readyIn, startX, startY, endX, endY, lineColor,
        input  rastReady, rastDone
    );

    modport slave (
        input  readyIn, startX, startY, endX, endY, lineColor,
        output rastReady, rastDone
    );
endinterface

// File: rtl/line_dispatcher.sv
// Queues line commands in a small FIFO and issues them one at a time to the
// rasterizer, holding operands until done, and counts completed lines.

module line_dispatcher #(
    parameter int DEPTH   = 8,
    parameter int COORD_W = 11,
    parameter int COLOR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    line_cmd_if.slave              cmd,
    line_rast_if.master            rast,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] fifoCount,
    output logic [15:0]            lineCount,
    output logic                   idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 4 * COORD_W + COLOR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    // DEPTH is a power of two, so the natural wrap of AW bits is the modulo.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
        return ptr + AW'(1);
    endfunction

    logic [EW-1:0]      mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    state_t             state_r;
    state_t             state_s;
    logic               ready_in_r;
    logic [COORD_W-1:0] start_x_r;
    logic [COORD_W-1:0] start_y_r;
    logic [COORD_W-1:0] end_x_r;
    logic [COORD_W-1:0] end_y_r;
    logic [COLOR_W-1:0] color_r;
    logic [15:0]        line_count_r;

    logic               full_s;
    logic               empty_s;
    logic               cmd_ready_s;
    logic               push_s;
    logic               pop_s;
    logic               done_s;
    logic [EW-1:0]      wdata_s;
    logic [EW-1:0]      head_s;

    assign full_s      = (count_r == CW'(DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    assign cmd_ready_s = !full_s && !flush;
    assign push_s      = cmd.cmdValid && cmd_ready_s;
    // Pop is decided from pre-edge state, so a same-edge flush still issues the head.
    assign pop_s       = (state_r == ST_IDLE) && !empty_s && rast.rastReady;
    assign done_s      = (state_r == ST_WAIT) && rast.rastDone;
    assign wdata_s     = {cmd.cmdStartX, cmd.cmdStartY, cmd.cmdEndX, cmd.cmdEndY, cmd.cmdColor};
    assign head_s      = mem_r[rd_ptr_r];

    // Next-state logic for the issue FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (rast.rastDone) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and the registered issue strobe (high exactly in ISSUE).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ready_in_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            ready_in_r <= (state_s == ST_ISSUE);
        end
    end

    // FIFO storage; contents need no reset because the count guards every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata_s;
        end
    end

    // FIFO pointers and occupancy; flush collapses the read pointer onto the write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (flush) begin
                rd_ptr_r <= wr_ptr_r;
                count_r  <= {CW{1'b0}};
            end else begin
                if (pop_s) begin
                    rd_ptr_r <= ptr_next(rd_ptr_r);
                end
                if (push_s && !pop_s) begin
                    count_r <= count_r + CW'(1);
                end else if (!push_s && pop_s) begin
                    count_r <= count_r - CW'(1);
                end
            end
        end
    end

    // Operand registers load only when a line is taken from the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_x_r <= {COORD_W{1'b0}};
            start_y_r <= {COORD_W{1'b0}};
            end_x_r   <= {COORD_W{1'b0}};
            end_y_r   <= {COORD_W{1'b0}};
            color_r   <= {COLOR_W{1'b0}};
        end else if (pop_s) begin
            {start_x_r, start_y_r, end_x_r, end_y_r, color_r} <= head_s;
        end
    end

    // Completed-line counter, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_count_r <= 16'd0;
        end else if (done_s) begin
            line_count_r <= line_count_r + 16'd1;
        end
    end

    assign cmd.cmdReady   = cmd_ready_s;
    assign rast.readyIn   = ready_in_r;
    assign rast.startX    = start_x_r;
    assign rast.startY    = start_y_r;
    assign rast.endX      = end_x_r;
    assign rast.endY      = end_y_r;
    assign rast.lineColor = color_r;
    assign fifoCount      = count_r;
    assign lineCount      = line_count_r;
    assign idle           = empty_s && (state_r == ST_IDLE) && rast.rastReady;

endmodule

// File: doc/line_dispatcher.md
# line_dispatcher

Initiator side of the rasterizer's line handshake (`readyIn` / `rastReady` / `done`). It accepts line commands (endpoints plus colour) from the vector generator into a small FIFO. It issues one line at a time to the rasterizer and holds the operands stable until the rasterizer reports `done`. It also counts completed lines so the frame controller can track drawing progress.

## Interface

Parameters:

- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `COORD_W`, 11: coordinate width, signed two's complement and centre-origin, matching the rasterizer inputs.
- `COLOR_W`, 4: line colour width.

Ports:

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmdValid`  in  1  upstream offers a command this cycle.
- `cmdReady`  out  1  the dispatcher can accept a command; equals FIFO not full and `flush` low.
- `cmdStartX`, `cmdStartY`, `cmdEndX`, `cmdEndY`  in  `COORD_W` each  line endpoints.
- `cmdColor`  in  `COLOR_W`  line colour.
- `flush`  in  1  synchronous discard of all queued, not-yet-issued commands.
- `rastReady`  in  1  rasterizer is idle.
- `rastDone`  in  1  one-cycle pulse from the rasterizer when a line completes.
- `readyIn`  out  1  one-cycle issue strobe to the rasterizer.
- `startX`, `startY`, `endX`, `endY`  out  `COORD_W` each  registered operands to the rasterizer.
- `lineColor`  out  `COLOR_W`  registered colour to the rasterizer.
- `fifoCount`  out  `$clog2(DEPTH)+1`  number of queued entries.
- `lineCount`  out  16  number of completed lines; wraps modulo 2^16.
- `idle`  out  1  FIFO empty, FSM in IDLE and `rastReady` high.

## Operation

- Push occurs when `cmdValid && cmdReady` at a clock edge. Commands are stored in order.
- The FSM has three states: IDLE, ISSUE and WAIT.
  - IDLE → ISSUE when the FIFO is non-empty and `rastReady` is high. On that edge the dispatcher pops the head entry and loads the five operand registers.
  - ISSUE → WAIT unconditionally. `readyIn` is 1 in ISSUE only (Moore output).
  - WAIT → IDLE when `rastDone` is high. On that edge `lineCount` increments.
  - Otherwise each state holds.
- `rastDone` is ignored in IDLE and ISSUE.
- `rastReady` is ignored outside IDLE.
- Operand registers change only on the IDLE→ISSUE edge. They stay stable through ISSUE and WAIT, and hold their last values while IDLE.
- Same-edge push and pop: both take effect and `fifoCount` is unchanged.
  - A push into an empty FIFO cannot be popped on the same edge; pop needs the FIFO to be non-empty beforehand.
- Full FIFO: `cmdReady` is 0 and `cmdValid` has no effect.
- Flush:
  - On an edge with `flush` high, the read and write pointers are equal and `fifoCount` is 0.
  - `cmdReady` is 0 while `flush` is high, so no push is possible.
  - An IDLE→ISSUE pop on the same edge still completes with the head entry, because the pop is decided from pre-edge state.
  - The in-flight line (ISSUE or WAIT) is unaffected.
- Pointers wrap modulo `DEPTH`. Full and empty are distinguished by `fifoCount`, not by pointer equality alone.
- Zero-length lines (start equals end) are dispatched normally. The rasterizer still returns `rastDone`.

## Timing

- Reset values (asynchronous, output changes without a clock edge):
  - FSM is in IDLE.
  - FIFO is empty; `fifoCount` = 0 and `cmdReady` = 1.
  - `readyIn` = 0.
  - All operand outputs are 0.
  - `lineCount` = 0.
  - `idle` follows `rastReady`.
- Reset mid-line: queued and in-flight state are lost. `readyIn` drops immediately. The rasterizer is reset alongside by the system reset.
- Latency, with the rasterizer idle and the FIFO empty:
  - Command pushed at edge N.
  - IDLE→ISSUE at edge N+1.
  - `readyIn` high between N+1 and N+2.
  - Rasterizer captures operands at edge N+2.
- Back-to-back lines: `rastDone` sampled at edge M gives WAIT→IDLE. The rasterizer returns to its IDLE at M, so `rastReady` is high in cycle M. The dispatcher takes IDLE→ISSUE at M+1 if the FIFO is non-empty. This gives a minimum gap of 2 cycles from a `done` pulse to the next `readyIn`.
- `readyIn` is never high for two consecutive cycles.
- At most one line is outstanding at a time.
- `cmdReady`, `idle` and `fifoCount` are derived from registered state plus `flush` / `rastReady`. They have no dependence on `cmdValid`.

## Test plan

- **Single line.** Reset, then push (-25,50)→(75,250) with colour 4'hA, using a rasterizer model with 3-cycle line processing. Required: `readyIn` is a single pulse 2 edges after the push, operands match the push, `lineCount` = 1 after `rastDone`, and `idle` = 1 afterwards.
- **Fill to full.** Stall the rasterizer (`rastReady` = 0) and push 9 commands. Required: the first 8 are accepted, `cmdReady` = 0 and `fifoCount` = 8, the 9th is not stored, and after release the lines issue in push order.
- **Concurrent push and pop.** With the FIFO at count 3, push on the same edge as IDLE→ISSUE. Required: `fifoCount` stays 3 and the order is preserved across pointer wrap (push 20 lines total through a DEPTH 8 FIFO).
- **Flush during WAIT with 4 queued.** Required: `fifoCount` is 0 at the next edge, the in-flight line completes, and no further `readyIn` occurs.
- **Spurious handshake signals.** Assert `rastDone` in IDLE. Required: `lineCount` is unchanged. Hold `rastReady` high throughout a line. Required: no second `readyIn` before `rastDone`.
- **Asynchronous reset mid-operation.** Assert `rst` between edges during ISSUE. Required: `readyIn` = 0, `fifoCount` = 0 and `lineCount` = 0 before the next edge.
